// File: rtl/image_spike_encoder_pkg.sv
// Shared types and constants for the image spike encoder.
// Encoder/handshake state codes, the default pixel type, and (when the
// SPIKE_ENC_LFSR_EN macro is defined) the accumulator-init LFSR constants and step function.
package image_spike_encoder_pkg;

  typedef logic [1:0] enc_state_t;

  localparam enc_state_t ST_IDLE    = 2'd0;
  localparam enc_state_t ST_SCAN    = 2'd1;
  localparam enc_state_t ST_REQ     = 2'd2;
  localparam enc_state_t ST_RELEASE = 2'd3;

  localparam int unsigned PIXEL_BITS_DEF = 8;
  typedef logic [PIXEL_BITS_DEF-1:0] pixel_t;

`ifdef SPIKE_ENC_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci step: shift left, feed back XOR of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
`endif

endpackage

// File: rtl/image_spike_encoder_aer_4phase_tx.sv
// 4-phase AER transmitter: one event at a time on a REQ/ACK link.
// Ports: CLK, RST (sync, active-high); send/addr start an event when idle;
// AER_ACK from the receiver; AER_REQ/AER_ADDR registered link outputs;
// done_c is high in the cycle the receiver drops ACK (event complete).
module image_spike_encoder_aer_4phase_tx
  import image_spike_encoder_pkg::*;
#(
  parameter int unsigned M = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         send,
  input  logic [M-1:0] addr,
  input  logic         AER_ACK,
  output logic         AER_REQ,
  output logic [M-1:0] AER_ADDR,
  output logic         done_c
);

  enc_state_t   state_q;
  enc_state_t   state_d;
  logic         req_d;
  logic [M-1:0] addr_d;

  // Handshake next-state: raise REQ, drop it on ACK, finish when ACK falls.
  always_comb begin
    state_d = state_q;
    req_d   = AER_REQ;
    addr_d  = AER_ADDR;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          req_d   = 1'b1;
          addr_d  = addr;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (AER_ACK) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!AER_ACK) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and link registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      AER_REQ  <= 1'b0;
      AER_ADDR <= '0;
    end else begin
      state_q  <= state_d;
      AER_REQ  <= req_d;
      AER_ADDR <= addr_d;
    end
  end

endmodule

// File: rtl/image_spike_encoder.sv
// Rate encoder: snapshots an image on NEW_IMAGE and emits one AER event per
// accumulator carry while scanning all pixels once per time step.
// Ports: CLK, RST (sync, active-high); IMAGE pixel array and NEW_IMAGE from the
// AXI slave; AER_ADDR/AER_REQ/AER_ACK 4-phase link to the SNN; TIMESTEP_DONE and
// ENC_DONE 1-cycle pulses; ENC_BUSY high while an image is being encoded.
// Build option: SPIKE_ENC_LFSR_EN seeds accumulators from an LFSR instead of 0.
module image_spike_encoder
  import image_spike_encoder_pkg::*;
#(
  parameter int unsigned N               = 256,
  parameter int unsigned M               = 8,
  parameter int unsigned IMAGE_SIZE      = 256,
  parameter int unsigned IMAGE_SIZE_BITS = 8,
  parameter int unsigned PIXEL_BITS      = 8,
  parameter int unsigned NUM_TIMESTEPS   = 16,
  parameter int unsigned TS_BITS         = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  input  logic                                  NEW_IMAGE,
  output logic [M-1:0]                          AER_ADDR,
  output logic                                  AER_REQ,
  input  logic                                  AER_ACK,
  output logic                                  TIMESTEP_DONE,
  output logic                                  ENC_BUSY,
  output logic                                  ENC_DONE
);

  enc_state_t                 state_q;
  enc_state_t                 state_d;
  logic [IMAGE_SIZE_BITS-1:0] pix_q;
  logic [IMAGE_SIZE_BITS-1:0] pix_d;
  logic [TS_BITS-1:0]         ts_q;
  logic [TS_BITS-1:0]         ts_d;
  logic                       busy_d;
  logic                       ts_done_d;
  logic                       enc_done_d;
  logic                       load_c;
  logic                       acc_we_c;
  logic                       send_c;
  logic                       advance_c;
  logic                       tx_done_c;
  logic                       pix_in_range_c;
  logic [PIXEL_BITS:0]        sum_c;

  logic [PIXEL_BITS-1:0] img_q [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0] acc_q [IMAGE_SIZE];

  // Phase accumulate for the current pixel; the top bit is the spike carry.
  assign sum_c = {1'b0, acc_q[pix_q]} + {1'b0, img_q[pix_q]};
  // Addresses outside the SNN are never emitted.
  assign pix_in_range_c = (32'(pix_q) < N);

`ifdef SPIKE_ENC_LFSR_EN
  logic [15:0]           lfsr_q;
  logic [15:0]           lfsr_end_c;
  logic [PIXEL_BITS-1:0] init_c [IMAGE_SIZE];

  // Unrolled LFSR walk: one step per pixel, all within the load cycle.
  always_comb begin
    logic [15:0] s;
    s = lfsr_q;
    for (int i = 0; i < int'(IMAGE_SIZE); i++) begin
      s         = lfsr_next(s);
      init_c[i] = s[PIXEL_BITS-1:0];
    end
    lfsr_end_c = s;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= LFSR_SEED;
    end else if (load_c) begin
      lfsr_q <= lfsr_end_c;
    end
  end
`endif

  // Encoder next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    ts_d       = ts_q;
    busy_d     = ENC_BUSY;
    ts_done_d  = 1'b0;
    enc_done_d = 1'b0;
    load_c     = 1'b0;
    acc_we_c   = 1'b0;
    send_c     = 1'b0;
    advance_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (NEW_IMAGE) begin
          load_c  = 1'b1;
          state_d = ST_SCAN;
          pix_d   = '0;
          ts_d    = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        acc_we_c = 1'b1;
        if (sum_c[PIXEL_BITS] && pix_in_range_c) begin
          send_c  = 1'b1;
          state_d = ST_REQ;
        end else begin
          advance_c = 1'b1;
        end
      end
      ST_REQ: begin
        if (AER_ACK) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (tx_done_c) advance_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Move to the next pixel; wrapping ends a time step, the last step ends the image.
    if (advance_c) begin
      state_d = ST_SCAN;
      if (pix_q == IMAGE_SIZE_BITS'(IMAGE_SIZE - 1)) begin
        pix_d     = '0;
        ts_done_d = 1'b1;
        if (ts_q == TS_BITS'(NUM_TIMESTEPS - 1)) begin
          ts_d       = '0;
          enc_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          ts_d = ts_q + TS_BITS'(1);
        end
      end else begin
        pix_d = pix_q + IMAGE_SIZE_BITS'(1);
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      pix_q         <= '0;
      ts_q          <= '0;
      ENC_BUSY      <= 1'b0;
      TIMESTEP_DONE <= 1'b0;
      ENC_DONE      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      ts_q          <= ts_d;
      ENC_BUSY      <= busy_d;
      TIMESTEP_DONE <= ts_done_d;
      ENC_DONE      <= enc_done_d;
    end
  end

  // Image buffer and accumulators: bulk load, then one read-modify-write per cycle.
  always_ff @(posedge CLK) begin
    if (load_c) begin
      for (int i = 0; i < int'(IMAGE_SIZE); i++) begin
        img_q[i] <= IMAGE[i];
`ifdef SPIKE_ENC_LFSR_EN
        acc_q[i] <= init_c[i];
`else
        acc_q[i] <= '0;
`endif
      end
    end else if (acc_we_c) begin
      acc_q[pix_q] <= sum_c[PIXEL_BITS-1:0];
    end
  end

  image_spike_encoder_aer_4phase_tx #(
    .M (M)
  ) u_aer_tx (
    .CLK      (CLK),
    .RST      (RST),
    .send     (send_c),
    .addr     (M'(pix_q)),
    .AER_ACK  (AER_ACK),
    .AER_REQ  (AER_REQ),
    .AER_ADDR (AER_ADDR),
    .done_c   (tx_done_c)
  );

endmodule

// File: tb/tb_image_spike_encoder.sv
// Self-checking bench for image_spike_encoder (T=8, init 0). Expected event
// streams come from the closed-form rate rule: pixel v fires in step s when
// floor((s+1)*v/256) > floor(s*v/256).
module tb_image_spike_encoder;

  localparam int unsigned T  = 8;
  localparam int unsigned IS = 256;
  localparam int unsigned PB = 8;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [IS-1:0][PB-1:0] IMAGE = '0;
  logic                  NEW_IMAGE = 1'b0;
  logic                  AER_ACK;
  logic [7:0]            AER_ADDR;
  logic                  AER_REQ;
  logic                  TIMESTEP_DONE;
  logic                  ENC_BUSY;
  logic                  ENC_DONE;

  image_spike_encoder #(
    .NUM_TIMESTEPS (T),
    .TS_BITS       (3)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .IMAGE         (IMAGE),
    .NEW_IMAGE     (NEW_IMAGE),
    .AER_ADDR      (AER_ADDR),
    .AER_REQ       (AER_REQ),
    .AER_ACK       (AER_ACK),
    .TIMESTEP_DONE (TIMESTEP_DONE),
    .ENC_BUSY      (ENC_BUSY),
    .ENC_DONE      (ENC_DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Receiver model: ACK follows REQ after ack_delay cycles unless forced.
  logic [7:0] ack_pipe = '0;
  int         ack_delay = 3;
  logic       ack_force_en = 1'b0;
  logic       ack_force = 1'b0;
  always @(posedge CLK) ack_pipe <= {ack_pipe[6:0], AER_REQ};
  assign AER_ACK = ack_force_en ? ack_force : ack_pipe[ack_delay-1];

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Monitor (negedge): event stream, per-step pulses, cycle numbers relative to load edge.
  int   e0 = 0;
  int   td_seen = 0;
  logic req_prev = 1'b0;
  int   mon_addr[$];
  int   mon_step[$];
  int   td_cyc[$];
  int   done_cyc[$];
  always @(negedge CLK) begin
    if (AER_REQ && !req_prev) begin
      mon_addr.push_back(int'(AER_ADDR));
      mon_step.push_back(td_seen);
    end
    if (TIMESTEP_DONE) begin
      td_cyc.push_back(edge_cnt - e0);
      td_seen <= td_seen + 1;
    end
    if (ENC_DONE) done_cyc.push_back(edge_cnt - e0);
    req_prev <= AER_REQ;
  end

  logic [7:0] img_v [IS];
  int exp_addr[$];
  int exp_step[$];
  int ev_base, step_base, td_base, done_base;

  function automatic void build_model();
    exp_addr.delete();
    exp_step.delete();
    for (int s = 0; s < int'(T); s++)
      for (int i = 0; i < int'(IS); i++)
        if (((s + 1) * int'(img_v[i])) / 256 > (s * int'(img_v[i])) / 256) begin
          exp_addr.push_back(i);
          exp_step.push_back(s);
        end
  endfunction

  // Index of first difference between observed and expected streams, -1 if equal.
  function automatic int first_diff();
    int got_n;
    got_n = mon_addr.size() - ev_base;
    for (int k = 0; k < exp_addr.size() && k < got_n; k++)
      if (mon_addr[ev_base+k] != exp_addr[k] ||
          mon_step[ev_base+k] - step_base != exp_step[k]) return k;
    if (got_n != exp_addr.size()) return (got_n < exp_addr.size()) ? got_n : exp_addr.size();
    return -1;
  endfunction

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic start_image();
    for (int i = 0; i < int'(IS); i++) IMAGE[i] = img_v[i];
    NEW_IMAGE = 1'b1;
    e0        = edge_cnt;
    ev_base   = mon_addr.size();
    step_base = td_seen;
    td_base   = td_cyc.size();
    done_base = done_cyc.size();
    step();
    NEW_IMAGE = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      step();
      if (ENC_DONE) begin
        ok = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) step();
    checks++;
    if ({AER_REQ, AER_ADDR, TIMESTEP_DONE, ENC_BUSY, ENC_DONE} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 000",
               {AER_REQ, AER_ADDR, TIMESTEP_DONE, ENC_BUSY, ENC_DONE});
    end
    RST = 1'b0;
    repeat (4) step();
    checks++;
    if (ENC_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b required 0", ENC_BUSY);
    end
  endtask

  task automatic test_zero_image();
    bit ok;
    int d;
    for (int i = 0; i < int'(IS); i++) img_v[i] = 8'd0;
    ack_delay = 3;
    start_image();
    checks++;
    if (ENC_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy: got %b required 1", ENC_BUSY);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_timeout: ENC_DONE got none required one");
    end
    d = mon_addr.size() - ev_base;
    checks++;
    if (d != 0) begin
      errors++;
      $display("FAIL zero_events: got %0d required 0", d);
    end
    checks++;
    if (td_cyc.size() - td_base != int'(T)) begin
      errors++;
      $display("FAIL zero_td_count: got %0d required %0d", td_cyc.size() - td_base, T);
    end
    for (int k = 0; k < int'(T); k++)
      if (td_base + k < td_cyc.size()) begin
        checks++;
        if (td_cyc[td_base+k] != 256 * (k + 1) + 1) begin
          errors++;
          $display("FAIL zero_td_cycle_%0d: got %0d required %0d", k, td_cyc[td_base+k], 256 * (k + 1) + 1);
        end
      end
    checks++;
    if (done_cyc.size() - done_base != 1 || done_cyc[done_cyc.size()-1] != 2049) begin
      errors++;
      $display("FAIL zero_enc_done: got %0d pulses last at %0d required 1 at 2049",
               done_cyc.size() - done_base, (done_cyc.size() > 0) ? done_cyc[done_cyc.size()-1] : -1);
    end
    checks++;
    if (ENC_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy_after: got %b required 0", ENC_BUSY);
    end
  endtask

  task automatic test_single_pixel();
    bit ok;
    int d;
    for (int i = 0; i < int'(IS); i++) img_v[i] = 8'd0;
    img_v[5] = 8'd255;
    build_model();
    ack_delay = 3;
    start_image();
    wait_done(ok);
    d = first_diff();
    checks++;
    if (!ok || d >= 0) begin
      errors++;
      $display("FAIL single_events: done=%0b first diff %0d got %0d events required %0d",
               ok, d, mon_addr.size() - ev_base, exp_addr.size());
    end
    checks++;
    if (td_cyc.size() - td_base != int'(T)) begin
      errors++;
      $display("FAIL single_td_count: got %0d required %0d", td_cyc.size() - td_base, T);
    end
  endtask

  task automatic test_two_pixels();
    bit ok;
    int d;
    for (int i = 0; i < int'(IS); i++) img_v[i] = 8'd0;
    img_v[3]   = 8'd128;
    img_v[200] = 8'd64;
    build_model();
    ack_delay = 3;
    start_image();
    wait_done(ok);
    d = first_diff();
    checks++;
    if (!ok || d >= 0) begin
      errors++;
      $display("FAIL two_events: done=%0b first diff %0d got %0d events required %0d",
               ok, d, mon_addr.size() - ev_base, exp_addr.size());
    end
  endtask

  task automatic test_ack_hold();
    bit ok;
    bit seen;
    bit stable;
    int d;
    for (int i = 0; i < int'(IS); i++) img_v[i] = 8'd0;
    img_v[5] = 8'd255;
    build_model();
    ack_delay    = 3;
    ack_force_en = 1'b1;
    ack_force    = 1'b0;
    start_image();
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (AER_REQ) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hold_req_seen: AER_REQ got 0 required 1");
    end
    stable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (AER_REQ !== 1'b1 || AER_ADDR !== 8'd5 || TIMESTEP_DONE !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable: req %b addr %0d got unstable required req 1 addr 5", AER_REQ, AER_ADDR);
    end
    ack_force = 1'b1;
    step();
    checks++;
    if (AER_REQ !== 1'b0 || AER_ADDR !== 8'd5) begin
      errors++;
      $display("FAIL hold_req_fall: req %b addr %0d required req 0 addr 5", AER_REQ, AER_ADDR);
    end
    ack_force_en = 1'b0;
    ack_force    = 1'b0;
    wait_done(ok);
    d = first_diff();
    checks++;
    if (!ok || d >= 0) begin
      errors++;
      $display("FAIL hold_events: done=%0b first diff %0d got %0d events required %0d",
               ok, d, mon_addr.size() - ev_base, exp_addr.size());
    end
  endtask

  task automatic test_new_image_ignored();
    bit ok;
    int d;
    for (int i = 0; i < int'(IS); i++) img_v[i] = 8'd0;
    img_v[5] = 8'd255;
    build_model();
    ack_delay = 3;
    start_image();
    repeat (300) step();
    for (int i = 0; i < int'(IS); i++) IMAGE[i] = 8'($urandom_range(1, 255));
    NEW_IMAGE = 1'b1;
    step();
    NEW_IMAGE = 1'b0;
    checks++;
    if (ENC_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL repulse_busy: got %b required 1", ENC_BUSY);
    end
    wait_done(ok);
    d = first_diff();
    checks++;
    if (!ok || d >= 0) begin
      errors++;
      $display("FAIL repulse_events: done=%0b first diff %0d got %0d events required %0d",
               ok, d, mon_addr.size() - ev_base, exp_addr.size());
    end
  endtask

  task automatic test_reset_in_req();
    bit ok;
    bit seen;
    int d;
    for (int i = 0; i < int'(IS); i++) img_v[i] = 8'd0;
    img_v[5] = 8'd255;
    build_model();
    ack_delay = 3;
    start_image();
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (AER_REQ) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_req_seen: AER_REQ got 0 required 1");
    end
    RST = 1'b1;
    step();
    checks++;
    if (AER_REQ !== 1'b0 || ENC_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_req: req %b busy %b required 0 0", AER_REQ, ENC_BUSY);
    end
    RST = 1'b0;
    repeat (10) step();
    start_image();
    wait_done(ok);
    d = first_diff();
    checks++;
    if (!ok || d >= 0) begin
      errors++;
      $display("FAIL rst_restart_events: done=%0b first diff %0d got %0d events required %0d",
               ok, d, mon_addr.size() - ev_base, exp_addr.size());
    end
  endtask

  task automatic test_random_sparse();
    bit ok;
    int d;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(IS); i++) img_v[i] = 8'd0;
      for (int j = 0; j < 12; j++) img_v[$urandom_range(0, IS - 1)] = 8'($urandom_range(1, 255));
      build_model();
      ack_delay = int'($urandom_range(1, 6));
      start_image();
      wait_done(ok);
      d = first_diff();
      checks++;
      if (!ok || d >= 0) begin
        errors++;
        $display("FAIL sparse_%0d_events: done=%0b first diff %0d got %0d events required %0d",
                 r, ok, d, mon_addr.size() - ev_base, exp_addr.size());
      end
      checks++;
      if (td_cyc.size() - td_base != int'(T) || done_cyc.size() - done_base != 1) begin
        errors++;
        $display("FAIL sparse_%0d_pulses: td %0d done %0d required %0d 1",
                 r, td_cyc.size() - td_base, done_cyc.size() - done_base, T);
      end
    end
  endtask

  task automatic test_back_to_back_dense();
    bit ok;
    int d;
    for (int i = 0; i < int'(IS); i++) img_v[i] = 8'($urandom_range(0, 255));
    build_model();
    ack_delay = 1;
    start_image();
    wait_done(ok);
    d = first_diff();
    checks++;
    if (!ok || d >= 0) begin
      errors++;
      $display("FAIL dense_events: done=%0b first diff %0d got %0d events required %0d",
               ok, d, mon_addr.size() - ev_base, exp_addr.size());
    end
    checks++;
    if (done_cyc.size() - done_base != 1 || td_cyc.size() - td_base != int'(T) ||
        done_cyc[done_cyc.size()-1] != td_cyc[td_cyc.size()-1]) begin
      errors++;
      $display("FAIL dense_done_align: done %0d td %0d required 1 and %0d, same cycle",
               done_cyc.size() - done_base, td_cyc.size() - td_base, T);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_zero_image();
    test_single_pixel();
    test_two_pixels();
    test_ack_hold();
    test_new_image_ignored();
    test_reset_in_req();
    test_random_sparse();
    test_back_to_back_dense();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
